// File: rtl/execution_mdu_pkg.sv
// Shared encodings for the RV32 execute stage: opcodes, funct codes,
// MDU FSM states and the instruction field layout.
package execution_mdu_pkg;

    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNCT7_M    = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_inst_t;

    // Sign-extended B-type branch offset.
    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/execution_mdu_mdu_iter.sv
// Iterative RV32M unit: shift-add multiplier (MUL_STEP bits/cycle) and
// restoring divider (1 bit/cycle) on magnitudes, with sign fix-up at the end.
module mdu_iter
    import execution_mdu_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MUL_STEP      = 1,
    parameter int unsigned DIV_EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned MUL_ITERS = XLEN / MUL_STEP;
    localparam int unsigned CW        = $clog2(XLEN) + 1;
    localparam int unsigned MW        = XLEN + MUL_STEP;
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(1) << (XLEN - 1);

    mdu_state_e       state;
    logic [CW-1:0]    cnt;
    logic [XLEN-1:0]  acc_hi, acc_lo, mcand, special_res_q;
    logic [2:0]       op_q;
    logic             neg_q, neg_r, special_q;

    logic             is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, last;
    logic [XLEN-1:0]  special_res, hi_nxt, lo_nxt, quo_fix, rem_fix, final_res;
    logic [MW-1:0]    mul_sum;
    logic [XLEN:0]    div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;

    // Issue-time operand classification and divide corner cases.
    always_comb begin
        is_div   = op[2];
        a_signed = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
        b_signed = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
        a_neg    = a_signed && a[XLEN-1];
        b_neg    = b_signed && b[XLEN-1];
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && b_signed && (a == MOST_NEG) && (b == '1);
        special_res = '0;
        if (div_zero)     special_res = op[1] ? a : '1;
        else if (div_ovf) special_res = op[1] ? '0 : MOST_NEG;
    end

    // One iteration step plus the signed result of the final step.
    always_comb begin
        mul_sum   = MW'(acc_hi) + MW'(mcand) * MW'(acc_lo[MUL_STEP-1:0]);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
        if (state == MDU_MUL) begin
            {hi_nxt, lo_nxt} = (2*XLEN)'({mul_sum, acc_lo} >> MUL_STEP);
        end else begin
            hi_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_nxt = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
        end
        last = ((state == MDU_MUL) && (cnt == CW'(MUL_ITERS - 1))) ||
               ((state == MDU_DIV) && (cnt == CW'(XLEN - 1)));
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -lo_nxt : lo_nxt;
        rem_fix  = neg_r ? -hi_nxt : hi_nxt;
        if (special_q)       final_res = special_res_q;
        else if (!op_q[2])   final_res = (op_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else                 final_res = op_q[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= MDU_IDLE;
            cnt           <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            mcand         <= '0;
            op_q          <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            result        <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (start) begin
                        op_q          <= op;
                        neg_q         <= a_neg ^ b_neg;
                        neg_r         <= a_neg;
                        acc_hi        <= '0;
                        acc_lo        <= a_neg ? -a : a;
                        mcand         <= b_neg ? -b : b;
                        cnt           <= '0;
                        special_q     <= div_zero || div_ovf;
                        special_res_q <= special_res;
                        result        <= special_res;
                        if ((div_zero || div_ovf) && (DIV_EARLY_OUT != 0)) state <= MDU_DONE;
                        else state <= is_div ? MDU_DIV : MDU_MUL;
                    end
                end
                MDU_MUL, MDU_DIV: begin
                    if (flush) begin
                        state <= MDU_IDLE;
                    end else begin
                        acc_hi <= hi_nxt;
                        acc_lo <= lo_nxt;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            result <= final_res;
                            state  <= MDU_DONE;
                        end
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    assign busy = (state == MDU_MUL) || (state == MDU_DIV);
    assign done = (state == MDU_DONE);

endmodule

// File: rtl/execution_mdu.sv
// RV32 execute stage: zero-cycle ALU and branches, iterative M-extension
// unit that stalls the front pipeline through hold_en while it works.
module execution_mdu
    import execution_mdu_pkg::*;
#(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MUL_STEP      = 1,
    parameter int unsigned DIV_EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst,
    input  logic [31:0]     inst_addr,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic [4:0]      rd_addr,
    output logic            rd_we,
    output logic [XLEN-1:0] rd_data,
    output logic [31:0]     jump_addr,
    output logic            jump_en,
    output logic            hold_en
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam logic WIDE_SHAMT = (XLEN == 64);

    rv_inst_t        di;
    logic            is_mdu, mdu_start, mdu_busy, mdu_done;
    logic [XLEN-1:0] mdu_result, alu_res, sra_res;
    logic [4:0]      rd_q;
    logic [SHW-1:0]  shamt;
    logic [5:0]      imm_hi;
    logic            alu_valid, br_taken, shamt_ok, sub_op, arith;
    logic            unused_rs;

    assign di        = rv_inst_t'(inst);
    assign unused_rs = ^{di.rs1, di.rs2};
    assign is_mdu    = (di.opcode == INST_TYPE_R_M) && (di.funct7 == FUNCT7_M);
    assign mdu_start = is_mdu && !mdu_busy && !mdu_done;

    mdu_iter #(
        .XLEN          (XLEN),
        .MUL_STEP      (MUL_STEP),
        .DIV_EARLY_OUT (DIV_EARLY_OUT)
    ) u_mdu_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start),
        .flush  (flush),
        .op     (di.funct3),
        .a      (op1),
        .b      (op2),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rd_q <= '0;
        else if (mdu_start) rd_q <= di.rd;
    end

    // Integer ALU and branch condition decode.
    always_comb begin
        alu_valid = 1'b0;
        br_taken  = 1'b0;
        shamt     = op2[SHW-1:0];
        imm_hi    = di.funct7[6:1];
        shamt_ok  = WIDE_SHAMT || !di.funct7[0];
        sub_op    = (di.opcode == INST_TYPE_R_M) && di.funct7[5];
        arith     = (di.opcode == INST_TYPE_I) ? imm_hi[4] : di.funct7[5];
        sra_res   = $unsigned($signed(op1) >>> shamt);
        case (di.funct3)
            F3_ADD:  alu_res = sub_op ? op1 - op2 : op1 + op2;
            F3_SLL:  alu_res = op1 << shamt;
            F3_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
            F3_SLTU: alu_res = XLEN'(op1 < op2);
            F3_XOR:  alu_res = op1 ^ op2;
            F3_SR:   alu_res = arith ? sra_res : op1 >> shamt;
            F3_OR:   alu_res = op1 | op2;
            default: alu_res = op1 & op2;
        endcase
        case (di.opcode)
            INST_TYPE_I: begin
                if (di.funct3 == F3_SLL)     alu_valid = (imm_hi == 6'b000000) && shamt_ok;
                else if (di.funct3 == F3_SR) alu_valid = ((imm_hi == 6'b000000) || (imm_hi == 6'b010000)) && shamt_ok;
                else                         alu_valid = 1'b1;
            end
            INST_TYPE_R_M: begin
                alu_valid = (di.funct7 == FUNCT7_BASE) ||
                            ((di.funct7 == FUNCT7_ALT) && ((di.funct3 == F3_ADD) || (di.funct3 == F3_SR)));
            end
            INST_TYPE_B: begin
                case (di.funct3)
                    F3_BEQ:  br_taken = (op1 == op2);
                    F3_BNE:  br_taken = (op1 != op2);
                    F3_BLT:  br_taken = ($signed(op1) < $signed(op2));
                    F3_BGE:  br_taken = !($signed(op1) < $signed(op2));
                    F3_BLTU: br_taken = (op1 < op2);
                    F3_BGEU: br_taken = !(op1 < op2);
                    default: br_taken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // Output steering by MDU phase; everything reads as zero while in reset.
    always_comb begin
        rd_we     = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
        jump_en   = 1'b0;
        jump_addr = '0;
        hold_en   = 1'b0;
        if (!rst_n) begin
            hold_en = 1'b0;
        end else if (mdu_done) begin
            if (!flush) begin
                rd_we   = (rd_q != 5'd0);
                rd_addr = rd_q;
                rd_data = mdu_result;
            end
        end else if (mdu_busy) begin
            hold_en = !flush;
        end else if (is_mdu) begin
            hold_en = 1'b1;
        end else if (alu_valid) begin
            rd_we   = (di.rd != 5'd0);
            rd_addr = di.rd;
            rd_data = alu_res;
        end else if (br_taken) begin
            jump_en   = 1'b1;
            jump_addr = inst_addr + b_imm(inst);
        end
    end

endmodule

// File: tb/tb_execution_mdu.sv
// Directed bench for execution_mdu: ALU, branches, MUL/DIV latency and
// results, divide corner cases, flush and reset aborts.
module tb_execution_mdu;
    import execution_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst, inst_addr, op1, op2;
    logic        flush;
    logic [4:0]  rd_addr;
    logic        rd_we, jump_en, hold_en;
    logic [31:0] rd_data, jump_addr;

    int n_cmp = 0;
    int n_err = 0;

    execution_mdu #(.XLEN(32), .MUL_STEP(1), .DIV_EARLY_OUT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (inst),
        .inst_addr (inst_addr),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .rd_addr   (rd_addr),
        .rd_we     (rd_we),
        .rd_data   (rd_data),
        .jump_addr (jump_addr),
        .jump_en   (jump_en),
        .hold_en   (hold_en)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, INST_TYPE_I};
    endfunction

    function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, INST_TYPE_R_M};
    endfunction

    function automatic logic [31:0] mk_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], INST_TYPE_B};
    endfunction

    // Apply one instruction just after a rising edge; return at the next falling edge.
    task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic fl);
        @(posedge clk);
        #1;
        inst = i; op1 = a; op2 = b; inst_addr = pc; flush = fl;
        @(negedge clk);
    endtask

    task automatic check_alu(input string tag, input logic [31:0] i, input logic [31:0] a,
                             input logic [31:0] b, input logic we, input logic [4:0] rd,
                             input logic [31:0] exp);
        step(i, a, b, 32'h0, 1'b0);
        check_eq({tag, "_we"}, rd_we, we);
        check_eq({tag, "_rd"}, rd_addr, rd);
        check_eq({tag, "_data"}, rd_data, exp);
        check_eq({tag, "_hold"}, hold_en, 1'b0);
    endtask

    task automatic check_br(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic taken, input logic [31:0] tgt);
        step(mk_b(13'h1FF8, f3), a, b, 32'h100, 1'b0);
        check_eq({tag, "_en"}, jump_en, taken);
        check_eq({tag, "_addr"}, jump_addr, tgt);
        check_eq({tag, "_we"}, rd_we, 1'b0);
    endtask

    // Issue an MDU op, count hold_en cycles up to DONE, check result, then confirm no restart.
    task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_hold);
        int  hold_cnt;
        bit  seen;
        hold_cnt = 0;
        seen     = 1'b0;
        step(mk_r(FUNCT7_M, f3, 5'd3), a, b, 32'h0, 1'b0);
        check_eq({tag, "_issue_we"}, rd_we, 1'b0);
        for (int i = 0; i < 100 && !seen; i++) begin
            if (!hold_en) seen = 1'b1;
            else begin
                hold_cnt++;
                @(negedge clk);
            end
        end
        check_eq({tag, "_done_seen"}, seen, 1'b1);
        check_eq({tag, "_hold_cycles"}, hold_cnt, exp_hold);
        check_eq({tag, "_we"}, rd_we, 1'b1);
        check_eq({tag, "_rd"}, rd_addr, 5'd3);
        check_eq({tag, "_data"}, rd_data, exp);
        step(mk_i(12'h000, F3_ADD, 5'd0), 32'h0, 32'h0, 32'h0, 1'b0);
        check_eq({tag, "_no_restart"}, hold_en, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; inst_addr = 32'h0;
        inst = mk_i(12'hFFD, F3_ADD, 5'd1); op1 = 32'd5; op2 = 32'hFFFF_FFFD;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", rd_we, 1'b0);
        check_eq("rst_data", rd_data, 32'h0);
        check_eq("rst_addr", rd_addr, 5'd0);
        check_eq("rst_hold", hold_en, 1'b0);
        rst_n = 1'b1;

        // ALU
        check_alu("addi", mk_i(12'hFFD, F3_ADD, 5'd1), 32'd5, 32'hFFFF_FFFD, 1'b1, 5'd1, 32'd2);
        check_alu("srai", mk_i(12'h404, F3_SR, 5'd2), 32'h8000_0000, 32'h0000_0404, 1'b1, 5'd2, 32'hF800_0000);
        check_alu("srli", mk_i(12'h004, F3_SR, 5'd2), 32'h8000_0000, 32'h0000_0004, 1'b1, 5'd2, 32'h0800_0000);
        check_alu("sub", mk_r(FUNCT7_ALT, F3_ADD, 5'd5), 32'd3, 32'd5, 1'b1, 5'd5, 32'hFFFF_FFFE);
        check_alu("slt", mk_r(FUNCT7_BASE, F3_SLT, 5'd6), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6, 32'd1);
        check_alu("sltu", mk_r(FUNCT7_BASE, F3_SLTU, 5'd6), 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd6, 32'd0);
        check_alu("sll", mk_r(FUNCT7_BASE, F3_SLL, 5'd7), 32'h0000_0003, 32'd33, 1'b1, 5'd7, 32'h0000_0006);
        check_alu("addi_x0", mk_i(12'h001, F3_ADD, 5'd0), 32'd5, 32'd1, 1'b0, 5'd0, 32'd6);
        check_alu("bad_op", 32'hFFFF_FFFF, 32'd5, 32'd1, 1'b0, 5'd0, 32'd0);
        check_eq("bad_op_jump", jump_en, 1'b0);

        step(mk_i(12'h007, F3_OR, 5'd8), 32'h10, 32'h7, 32'h0, 1'b1);
        check_eq("idle_flush_we", rd_we, 1'b1);
        check_eq("idle_flush_data", rd_data, 32'h17);

        // Branches
        check_br("blt", F3_BLT, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0000_00F8);
        check_br("bltu", F3_BLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
        check_br("bgeu", F3_BGEU, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0000_00F8);
        check_br("beq", F3_BEQ, 32'd4, 32'd5, 1'b0, 32'h0);

        // Multiply
        run_mdu("mul", F3_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 33);
        run_mdu("mulhu", F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 33);
        run_mdu("mulh", F3_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 32'hF8CC_93D6, 33);
        run_mdu("mulh_m1", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
        run_mdu("mul_m1", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33);
        run_mdu("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

        // Divide
        run_mdu("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_mdu("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_mdu("divu", F3_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33);
        run_mdu("remu", F3_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_mdu("div_z", F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_mdu("rem_z", F3_REM, 32'd5, 32'd0, 32'd5, 1);
        run_mdu("rem_z_neg", F3_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
        run_mdu("divu_z", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_mdu("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_mdu("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Flush at DIV iteration 10
        step(mk_r(FUNCT7_M, F3_DIV, 5'd3), 32'd100, 32'd7, 32'h0, 1'b0);
        check_eq("fl_issue_hold", hold_en, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check_eq("fl_hold", hold_en, 1'b0);
        check_eq("fl_we", rd_we, 1'b0);
        check_alu("fl_add", mk_r(FUNCT7_BASE, F3_ADD, 5'd4), 32'd3, 32'd4, 1'b1, 5'd4, 32'd7);
        check_alu("fl_add2", mk_r(FUNCT7_BASE, F3_XOR, 5'd4), 32'hF0, 32'hFF, 1'b1, 5'd4, 32'h0F);

        // Reset mid-MUL
        step(mk_r(FUNCT7_M, F3_MUL, 5'd3), 32'd9, 32'd9, 32'h0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_hold", hold_en, 1'b0);
        check_eq("rst_mid_we", rd_we, 1'b0);
        check_eq("rst_mid_data", rd_data, 32'h0);
        check_eq("rst_mid_addr", rd_addr, 5'd0);
        check_eq("rst_mid_jump", jump_en, 1'b0);
        inst = mk_r(FUNCT7_BASE, F3_ADD, 5'd4); op1 = 32'd3; op2 = 32'd4;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_rel_hold", hold_en, 1'b0);
        check_eq("rst_rel_we", rd_we, 1'b1);
        check_eq("rst_rel_data", rd_data, 32'd7);
        run_mdu("post_rst_mul", F3_MUL, 32'd9, 32'd9, 32'd81, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
